// File: rtl/add_pipe_pkg.sv
// Shared definitions for the pipelined carry/borrow adder (add_pipe).
package add_pipe_pkg;

    // Encoding of the sub input
    localparam logic ADD_MODE_ADD = 1'b0;
    localparam logic ADD_MODE_SUB = 1'b1;

    // Width of the carry-chain slice handled by each pipeline stage
    function automatic int chunk_w(input int w, input int stages);
        return w / stages;
    endfunction

endpackage

// File: rtl/add_pipe_stage.sv
// One slice of the pipelined adder: a CHUNK-bit adder with its result,
// carry and valid registers. The slice loads only when its advance input is set.
module add_pipe_stage
    import add_pipe_pkg::*;
#(
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             adv,
    input  logic             vld_in,
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum_p,
    output logic             cout_p,
    output logic             vld_p
);

    logic [CHUNK:0] total;

    assign total = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};

    // Occupancy flag: follows the upstream valid whenever this slice advances
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   vld_p <= 1'b0;
        else if (adv) vld_p <= vld_in;
    end

    // Slice result and carry: captured only when a real operation moves in
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_p  <= '0;
            cout_p <= 1'b0;
        end else if (adv && vld_in) begin
            sum_p  <= total[CHUNK-1:0];
            cout_p <= total[CHUNK];
        end
    end

endmodule

// File: rtl/add_pipe.sv
// Pipelined add/subtract with carry/borrow in and out and valid/ready on both
// sides. The carry chain is cut into STAGES equal slices, one register each.
// Optional macro ADD_PIPE_OVF_EN adds the signed-overflow output ovf.
module add_pipe
    import add_pipe_pkg::*;
#(
    parameter int WIREWIDTH = 7,
    parameter int STAGES    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic             ci,
    input  logic [WIREWIDTH:0] op1,
    input  logic [WIREWIDTH:0] op2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIREWIDTH:0] res,
    output logic             co
`ifdef ADD_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int W     = WIREWIDTH + 1;
    localparam int CHUNK = chunk_w(W, STAGES);

    if (STAGES < 1 || (W % STAGES) != 0) begin : g_bad_cfg
        $error("add_pipe: data width must split evenly into STAGES slices");
    end

    // Subtraction is op1 + ~op2 + !ci; the borrow is the inverted final carry
    logic [W-1:0] b_eff;
    logic         c_eff;

    assign b_eff = (sub == ADD_MODE_ADD) ? op2 : ~op2;
    assign c_eff = (sub == ADD_MODE_SUB) ? ~ci : ci;

    logic [STAGES-1:0]            vld;
    logic [STAGES-1:0]            adv;
    logic [STAGES-1:0]            cry;
    logic [STAGES-1:0][CHUNK-1:0] sum;
    logic                         nxt;

    // Advance chain: a slice moves when it is empty or its successor moves,
    // so bubbles collapse even while the consumer stalls
    always_comb begin
        nxt = out_ready;
        adv = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            adv[k] = !vld[k] || nxt;
            nxt    = adv[k];
        end
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [W-1:0]     a_p, b_p, acc_p, res_full;
        logic             sub_p;
        logic [W-1:0]     a_in, b_in, acc_in;
        logic             sub_in, c_in, v_in;
        logic [CHUNK-1:0] a_c, b_c;

        if (k == 0) begin : g_first
            assign a_in   = op1;
            assign b_in   = b_eff;
            assign acc_in = '0;
            assign sub_in = sub;
            assign c_in   = c_eff;
            assign v_in   = in_valid;
            assign a_c    = op1[CHUNK-1:0];
            assign b_c    = b_eff[CHUNK-1:0];
        end else begin : g_next
            assign a_in   = g_stage[k-1].a_p;
            assign b_in   = g_stage[k-1].b_p;
            assign acc_in = g_stage[k-1].res_full;
            assign sub_in = g_stage[k-1].sub_p;
            assign c_in   = cry[k-1];
            assign v_in   = vld[k-1];
            assign a_c    = g_stage[k-1].a_p[k*CHUNK +: CHUNK];
            assign b_c    = g_stage[k-1].b_p[k*CHUNK +: CHUNK];
        end

        add_pipe_stage #(.CHUNK(CHUNK)) u_stage (
            .clk    (clk),
            .rst_n  (rst_n),
            .adv    (adv[k]),
            .vld_in (v_in),
            .a      (a_c),
            .b      (b_c),
            .cin    (c_in),
            .sum_p  (sum[k]),
            .cout_p (cry[k]),
            .vld_p  (vld[k])
        );

        // Skew registers: pending operands, finished low slices and mode bit
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                a_p   <= '0;
                b_p   <= '0;
                acc_p <= '0;
                sub_p <= 1'b0;
            end else if (adv[k] && v_in) begin
                a_p   <= a_in;
                b_p   <= b_in;
                acc_p <= acc_in;
                sub_p <= sub_in;
            end
        end

        // Result so far: finished low slices plus this slice's sum
        always_comb begin
            res_full                   = acc_p;
            res_full[k*CHUNK +: CHUNK] = sum[k];
        end

        // The slot of acc_p under this slice is always replaced by sum[k]
        logic unused_acc;
        assign unused_acc = ^acc_p[k*CHUNK +: CHUNK];

        if (k == STAGES - 1) begin : g_last
            logic unused_skew;
            assign unused_skew = ^{a_p, b_p};
        end
    end

    assign in_ready  = adv[0];
    assign out_valid = vld[STAGES-1];
    assign res       = g_stage[STAGES-1].res_full;
    assign co        = cry[STAGES-1] ^ g_stage[STAGES-1].sub_p;

`ifdef ADD_PIPE_OVF_EN
    // With b already inverted for subtract, one rule covers both modes:
    // operands of equal sign producing a result of the other sign
    logic a_msb, b_msb;

    assign a_msb = g_stage[STAGES-1].a_p[W-1];
    assign b_msb = g_stage[STAGES-1].b_p[W-1];
    assign ovf   = (a_msb == b_msb) && (res[W-1] != a_msb);
`endif

endmodule

// File: tb/tb_add_pipe.sv
// Bench for add_pipe (WIREWIDTH=7, STAGES=2); checks ovf too when
// ADD_PIPE_OVF_EN is defined.
module tb_add_pipe;

    localparam int WW  = 7;
    localparam int W   = WW + 1;
    localparam int LAT = 2;

    typedef struct {
        logic [W-1:0] r;
        logic         c;
        logic         v;
        int           cy;
        bit           lat;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n, in_valid, in_ready, sub, ci, out_valid, out_ready, co;
    logic [W-1:0] op1, op2, res;
`ifdef ADD_PIPE_OVF_EN
    logic         ovf;
`endif

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t sb[$];
    exp_t cur;

    add_pipe #(.WIREWIDTH(WW), .STAGES(LAT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sub       (sub),
        .ci        (ci),
        .op1       (op1),
        .op2       (op2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .co        (co)
`ifdef ADD_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic s, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        int   ai, bi, ci_i, t;
        ai   = int'(a);
        bi   = int'(b);
        ci_i = c ? 1 : 0;
        if (!s) begin
            t   = ai + bi + ci_i;
            e.r = W'(t);
            e.c = (t >= (1 << W));
            e.v = (a[W-1] == b[W-1]) && (e.r[W-1] != a[W-1]);
        end else begin
            t   = ai - bi - ci_i;
            e.r = W'(t);
            e.c = (ai < bi + ci_i);
            e.v = (a[W-1] != b[W-1]) && (e.r[W-1] != a[W-1]);
        end
        e.cy  = 0;
        e.lat = 1'b0;
        return e;
    endfunction

    // Output side: every transfer is popped and compared in order
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL unexpected_result observed=%0h expected=none", res);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("res", 32'(res), 32'(e.r));
                chk("co", 32'(co), 32'(e.c));
`ifdef ADD_PIPE_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.v));
`endif
                if (e.lat) chk("latency", 32'(cyc - e.cy), 32'(LAT));
            end
        end
    end

    task automatic drive(input logic s, input logic c, input logic [W-1:0] a, input logic [W-1:0] b);
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        sub      = s;
        ci       = c;
        op1      = a;
        op2      = b;
        cur      = model(s, c, a, b);
    endtask

    task automatic wait_accept(input bit lat);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                cur.cy  = cyc;
                cur.lat = lat;
                sb.push_back(cur);
                ok = 1'b1;
            end
        end
        checks++;
        assert (ok) else begin
            errors++;
            $error("FAIL accept_timeout observed=%0d expected=1", ok);
        end
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        op1      = W'($urandom);
        op2      = W'($urandom);
        sub      = 1'($urandom);
        ci       = 1'($urandom);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(negedge clk);
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    task automatic op(input logic s, input logic c, input logic [W-1:0] a, input logic [W-1:0] b, input bit lat);
        drive(s, c, a, b);
        wait_accept(lat);
    endtask

    initial begin
        logic [W-1:0] held_r;
        logic         held_c;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        sub = 1'b0; ci = 1'b0; op1 = '0; op2 = '0;
        #12;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_res", 32'(res), 32'd0);
        chk("rst_co", 32'(co), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef ADD_PIPE_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // Directed arithmetic, including carry across the slice boundary
        op(1'b0, 1'b0, 8'hFF, 8'h01, 1'b1);
        idle();
        drain();
        op(1'b1, 1'b0, 8'h10, 8'h20, 1'b1);
        op(1'b1, 1'b1, 8'h20, 8'h10, 1'b1);
        op(1'b0, 1'b1, 8'hFF, 8'hFF, 1'b1);
        op(1'b1, 1'b1, 8'h00, 8'hFF, 1'b1);
        op(1'b1, 1'b0, 8'h5A, 8'h5A, 1'b1);
        op(1'b0, 1'b1, 8'h0F, 8'h00, 1'b1);
        idle();
        drain();

        // Back-to-back random mixed stream
        for (int i = 0; i < 16; i++)
            op(1'($urandom), 1'($urandom), W'($urandom), W'($urandom), 1'b1);
        idle();
        drain();

        // Consumer stall: two ops fill the pipe, the third must wait
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        op(1'b0, 1'b0, 8'h12, 8'h34, 1'b0);
        op(1'b1, 1'b0, 8'h40, 8'h41, 1'b0);
        drive(1'b0, 1'b1, 8'h80, 8'h80);
        @(negedge clk);
        held_r = res;
        held_c = co;
        chk("stall_res_head", 32'(held_r), 32'(sb[0].r));
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_out_valid", 32'(out_valid), 32'd1);
            chk("stall_res_hold", 32'(res), 32'(held_r));
            chk("stall_co_hold", 32'(co), 32'(held_c));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_accept(1'b0);
        idle();
        drain();

        // Reset with two operations in flight
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        op(1'b0, 1'b0, 8'h01, 8'h02, 1'b0);
        op(1'b0, 1'b0, 8'h03, 8'h04, 1'b0);
        idle();
        @(negedge clk);
        chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_res", 32'(res), 32'd0);
        chk("mid_rst_co", 32'(co), 32'd0);
        sb.delete();
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("post_rst_out_valid", 32'(out_valid), 32'd0);
        end
        op(1'b1, 1'b0, 8'h33, 8'h11, 1'b1);
        idle();
        drain();

`ifdef ADD_PIPE_OVF_EN
        op(1'b0, 1'b0, 8'h7F, 8'h01, 1'b1);
        op(1'b1, 1'b0, 8'h80, 8'h01, 1'b1);
        op(1'b0, 1'b0, 8'h01, 8'h01, 1'b1);
        idle();
        drain();
`endif

        repeat (3) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute guard so the run always ends
    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
